keyram_arbiter: RTL and testbench

- Owns the 16-row x 8-bit MSX key-matrix RAM port and shares it between three users: the PPI row scan (read-only), the PS/2 key updater (requester A) and the host/OSD key injector (requester B).
- A and B each issue atomic single-bit read-modify-write requests; the PPI scan is served whenever no RMW is in flight.
- Sits between the PS/2 keyboard decoder, the host SPI/OSD block, the PPI and the keyram instance.
- Also performs the full-matrix clear after reset and on demand.

---
 rtl/keyram_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_keyram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keyram_arbiter.sv
// Key-matrix RAM arbiter: PPI row scan, two single-bit RMW requesters and a full-matrix clear.
// Optional injected-key auto-release is built when KEYARB_AUTORELEASE_EN is defined.
module keyram_arbiter #(
    parameter logic [15:0] HOLD_TICKS = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_ena,
    input  logic [3:0] scan_row,
    output logic [7:0] scan_col,
    input  logic       a_req,
    input  logic [3:0] a_row,
    input  logic [2:0] a_bit,
    input  logic       a_press,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [3:0] b_row,
    input  logic [2:0] b_bit,
    input  logic       b_press,
    output logic       b_ack,
    input  logic       clr_req,
    output logic       busy,
    output logic [3:0] ram_addr,
    output logic       ram_we,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout,
    output logic [2:0] state_dbg
);

    // Handshake: a_req/b_req are levels held until the matching ack, which is a
    // single-clk pulse issued once the write of the granted RMW has been made.
    typedef enum logic [2:0] {
        S_CLR  = 3'd0,
        S_IDLE = 3'd1,
        S_RD   = 3'd2,
        S_MOD  = 3'd3,
        S_WR   = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] clr_cnt;
    logic       clr_pending;
    logic [1:0] scan_age;
    logic       rr_b;

    logic       grant_b;
    logic       grant_auto;
    logic [3:0] grant_row;
    logic [2:0] grant_bit;
    logic       grant_press;

    logic       rel_req;
    logic [3:0] hold_row;
    logic [2:0] hold_bit;

    logic       clr_hit;
    logic       req_b;
    logic       any_req;
    logic       pick_b;
    logic       grant_now;
    logic [3:0] sel_row;
    logic [2:0] sel_bit;
    logic       sel_press;
    logic       sel_auto;
    logic [7:0] mod_data;

    assign state_dbg = state;

    always_comb begin
        clr_hit   = clr_pending | clr_req;
        req_b     = b_req | rel_req;
        any_req   = a_req | req_b;
        pick_b    = req_b & (~a_req | rr_b);
        grant_now = (state == S_IDLE) & ~clr_hit & any_req;
        sel_row   = a_row;
        sel_bit   = a_bit;
        sel_press = a_press;
        sel_auto  = 1'b0;
        if (pick_b) begin
            // A real B request is served ahead of the internal release.
            if (b_req) begin
                sel_row   = b_row;
                sel_bit   = b_bit;
                sel_press = b_press;
            end else begin
                sel_row   = hold_row;
                sel_bit   = hold_bit;
                sel_press = 1'b0;
                sel_auto  = 1'b1;
            end
        end
        mod_data            = ram_dout;
        mod_data[grant_bit] = grant_press;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_CLR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clk_ena) begin
            case (state)
                S_CLR:   if (!clr_hit && clr_cnt == 4'd15) state_nxt = S_IDLE;
                S_IDLE:  if (clr_hit) state_nxt = S_CLR;
                         else if (any_req) state_nxt = S_RD;
                S_RD:    state_nxt = S_MOD;
                S_MOD:   state_nxt = S_WR;
                S_WR:    state_nxt = S_IDLE;
                default: state_nxt = S_CLR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt     <= 4'd0;
            ram_addr    <= 4'd0;
            ram_we      <= 1'b1;
            ram_din     <= 8'd0;
            scan_col    <= 8'hFF;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            busy        <= 1'b1;
            rr_b        <= 1'b0;
            clr_pending <= 1'b0;
            scan_age    <= 2'd0;
            grant_b     <= 1'b0;
            grant_auto  <= 1'b0;
            grant_row   <= 4'd0;
            grant_bit   <= 3'd0;
            grant_press <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            // Captured on any clk so a pulse between ticks is not lost.
            if (clr_req) clr_pending <= 1'b1;
            if (clk_ena) begin
                case (state)
                    S_CLR: begin
                        if (clr_hit) begin
                            clr_cnt     <= 4'd0;
                            ram_addr    <= 4'd0;
                            clr_pending <= 1'b0;
                        end else if (clr_cnt == 4'd15) begin
                            ram_we   <= 1'b0;
                            ram_addr <= scan_row;
                            busy     <= 1'b0;
                            scan_age <= 2'd0;
                        end else begin
                            clr_cnt  <= clr_cnt + 4'd1;
                            ram_addr <= clr_cnt + 4'd1;
                        end
                    end
                    S_IDLE: begin
                        if (clr_hit) begin
                            clr_cnt     <= 4'd0;
                            ram_addr    <= 4'd0;
                            ram_we      <= 1'b1;
                            ram_din     <= 8'd0;
                            busy        <= 1'b1;
                            clr_pending <= 1'b0;
                        end else if (any_req) begin
                            grant_b     <= pick_b;
                            grant_auto  <= sel_auto;
                            grant_row   <= sel_row;
                            grant_bit   <= sel_bit;
                            grant_press <= sel_press;
                            ram_addr    <= sel_row;
                            scan_age    <= 2'd0;
                            rr_b        <= ~pick_b;
                        end else begin
                            ram_addr <= scan_row;
                            if (scan_row != ram_addr)   scan_age <= 2'd0;
                            else if (scan_age != 2'd2)  scan_age <= scan_age + 2'd1;
                            if (scan_age == 2'd2) scan_col <= ~ram_dout;
                        end
                    end
                    S_MOD: begin
                        ram_din <= mod_data;
                        ram_we  <= 1'b1;
                    end
                    S_WR: begin
                        ram_we   <= 1'b0;
                        ram_addr <= scan_row;
                        scan_age <= 2'd0;
                        if (!grant_auto) begin
                            a_ack <= ~grant_b;
                            b_ack <= grant_b;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef KEYARB_AUTORELEASE_EN
    logic        hold_valid;
    logic [15:0] hold_cnt;

    assign rel_req = hold_valid & (hold_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_cnt   <= 16'd0;
            hold_row   <= 4'd0;
            hold_bit   <= 3'd0;
        end else if (clk_ena) begin
            if (state == S_CLR) begin
                hold_valid <= 1'b0;
            end else if (grant_now && pick_b && b_req && b_press) begin
                // A new injected press replaces the held key without releasing it.
                hold_valid <= 1'b1;
                hold_cnt   <= HOLD_TICKS;
                hold_row   <= b_row;
                hold_bit   <= b_bit;
            end else if (grant_now && pick_b && b_req &&
                         hold_valid && b_row == hold_row && b_bit == hold_bit) begin
                hold_valid <= 1'b0;
            end else if (grant_now && pick_b && !b_req) begin
                hold_valid <= 1'b0;
            end else if (hold_valid && hold_cnt != 16'd0) begin
                hold_cnt <= hold_cnt - 16'd1;
            end
        end
    end
`else
    logic unused_hold;
    assign unused_hold = ^{HOLD_TICKS, grant_now};
    assign rel_req     = 1'b0;
    assign hold_row    = 4'd0;
    assign hold_bit    = 3'd0;
`endif

endmodule

// File: tb/tb_keyram_arbiter.sv
// Directed bench for keyram_arbiter with a behavioural 16x8 synchronous key RAM.
module tb_keyram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_ena;
    logic [3:0] scan_row;
    logic [7:0] scan_col;
    logic       a_req, a_press, a_ack;
    logic [3:0] a_row;
    logic [2:0] a_bit;
    logic       b_req, b_press, b_ack;
    logic [3:0] b_row;
    logic [2:0] b_bit;
    logic       clr_req;
    logic       busy;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int div = 1;

    localparam logic [2:0] ST_CLR  = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_MOD  = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;

    keyram_arbiter #(.HOLD_TICKS(16'd10)) dut (
        .clk(clk), .reset(reset), .clk_ena(clk_ena),
        .scan_row(scan_row), .scan_col(scan_col),
        .a_req(a_req), .a_row(a_row), .a_bit(a_bit), .a_press(a_press), .a_ack(a_ack),
        .b_req(b_req), .b_row(b_row), .b_bit(b_bit), .b_press(b_press), .b_ack(b_ack),
        .clr_req(clr_req), .busy(busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Key RAM model: synchronous read, read-before-write.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clk_ena tick; returns at the following negedge.
    task automatic tick();
        for (int i = 0; i < div - 1; i++) begin
            clk_ena = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        clk_ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clk_ena = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_a(input logic req, input logic [3:0] row, input logic [2:0] bitn, input logic press);
        a_req = req; a_row = row; a_bit = bitn; a_press = press;
    endtask

    task automatic drive_b(input logic req, input logic [3:0] row, input logic [2:0] bitn, input logic press);
        b_req = req; b_row = row; b_bit = bitn; b_press = press;
    endtask

    initial begin
        reset = 1'b1; clk_ena = 1'b1; scan_row = 4'd8; clr_req = 1'b0;
        drive_a(1'b0, 4'd0, 3'd0, 1'b0);
        drive_b(1'b0, 4'd0, 3'd0, 1'b0);
        @(negedge clk);
        tick(); tick();
        check("rst_state", 16'(state_dbg), 16'(ST_CLR));
        check("rst_busy", 16'(busy), 16'd1);
        check("rst_we", 16'(ram_we), 16'd1);
        check("rst_addr", 16'(ram_addr), 16'd0);
        check("rst_col", 16'(scan_col), 16'hFF);
        check("rst_ack", 16'({a_ack, b_ack}), 16'd0);
        reset = 1'b0;

        // Power-up clear: 16 write ticks over rows 0..15.
        for (int k = 0; k < 16; k++) begin
            check("clr_we", 16'(ram_we), 16'd1);
            check("clr_addr", 16'(ram_addr), 16'(k));
            check("clr_din", 16'(ram_din), 16'd0);
            check("clr_busy", 16'(busy), 16'd1);
            tick();
        end
        check("clr_done_busy", 16'(busy), 16'd0);
        check("clr_done_we", 16'(ram_we), 16'd0);
        check("clr_done_addr", 16'(ram_addr), 16'd8);
        ticks(3);
        check("scan_row8_idle", 16'(scan_col), 16'hFF);

        // A presses row 8 bit 0; ack three ticks after the accept tick.
        drive_a(1'b1, 4'd8, 3'd0, 1'b1);
        tick();
        check("a1_rd", 16'(state_dbg), 16'(ST_RD));
        check("a1_addr", 16'(ram_addr), 16'd8);
        check("a1_ack_t1", 16'(a_ack), 16'd0);
        tick();
        check("a1_ack_t2", 16'(a_ack), 16'd0);
        tick();
        check("a1_wr_we", 16'(ram_we), 16'd1);
        check("a1_wr_din", 16'(ram_din), 16'h01);
        check("a1_ack_t3", 16'(a_ack), 16'd0);
        tick();
        check("a1_ack", 16'(a_ack), 16'd1);
        check("a1_we_off", 16'(ram_we), 16'd0);
        check("a1_row8", 16'(mem[8]), 16'h01);
        a_req = 1'b0;
        ticks(2);
        check("a1_col_hold", 16'(scan_col), 16'hFF);
        tick();
        check("a1_col", 16'(scan_col), 16'hFE);

        // B grant moves the round-robin pointer back to A.
        drive_b(1'b1, 4'd3, 3'd6, 1'b1);
        ticks(4);
        check("b1_ack", 16'(b_ack), 16'd1);
        check("b1_row3", 16'(mem[3]), 16'h40);
        b_req = 1'b0;

        // Simultaneous A and B to row 2: A first, then B sees A's write.
        scan_row = 4'd2;
        tick();
        drive_a(1'b1, 4'd2, 3'd3, 1'b1);
        drive_b(1'b1, 4'd2, 3'd5, 1'b1);
        ticks(4);
        check("ab_a_ack", 16'({a_ack, b_ack}), 16'b10);
        check("ab_row2_a", 16'(mem[2]), 16'h08);
        a_req = 1'b0;
        ticks(3);
        check("ab_b_pending", 16'(b_ack), 16'd0);
        tick();
        check("ab_b_ack", 16'({a_ack, b_ack}), 16'b01);
        check("ab_row2", 16'(mem[2]), 16'h28);
        b_req = 1'b0;
        ticks(3);
        check("ab_col", 16'(scan_col), 16'hD7);

        // Clear requested mid-RMW: ack still given, then a full clear.
        drive_a(1'b1, 4'd5, 3'd2, 1'b1);
        ticks(2);
        check("cm_mod", 16'(state_dbg), 16'(ST_MOD));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("cm_wr", 16'(state_dbg), 16'(ST_WR));
        check("cm_wr_din", 16'(ram_din), 16'h04);
        tick();
        check("cm_ack", 16'(a_ack), 16'd1);
        check("cm_row5", 16'(mem[5]), 16'h04);
        check("cm_idle_busy", 16'(busy), 16'd0);
        a_req = 1'b0;
        tick();
        check("cm_clr_state", 16'(state_dbg), 16'(ST_CLR));
        check("cm_clr_busy", 16'(busy), 16'd1);
        check("cm_clr_addr", 16'(ram_addr), 16'd0);
        ticks(15);
        check("cm_busy_15", 16'(busy), 16'd1);
        tick();
        check("cm_busy_16", 16'(busy), 16'd0);
        for (int r = 0; r < 16; r++) check("cm_row_zero", 16'(mem[4'(r)]), 16'd0);

        // clk_ena 1-in-4: same tick timing, ack one clk wide.
        div = 4;
        scan_row = 4'd6;
        drive_a(1'b1, 4'd6, 3'd7, 1'b1);
        ticks(3);
        check("d4_ack_t3", 16'(a_ack), 16'd0);
        check("d4_wr", 16'(state_dbg), 16'(ST_WR));
        tick();
        check("d4_ack", 16'(a_ack), 16'd1);
        check("d4_row6", 16'(mem[6]), 16'h80);
        a_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("d4_ack_width", 16'(a_ack), 16'd0);
        ticks(3);
        check("d4_col", 16'(scan_col), 16'h7F);
        drive_a(1'b1, 4'd6, 3'd7, 1'b0);
        ticks(4);
        check("d4_rel_ack", 16'(a_ack), 16'd1);
        check("d4_rel_row6", 16'(mem[6]), 16'h00);
        a_req = 1'b0;
        div = 1;
        tick();

`ifdef KEYARB_AUTORELEASE_EN
        begin
            int seen_b_ack;
            seen_b_ack = 0;
            drive_b(1'b1, 4'd4, 3'd7, 1'b1);
            ticks(4);
            check("ar_ack", 16'(b_ack), 16'd1);
            check("ar_row4_set", 16'(mem[4]), 16'h80);
            b_req = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (b_ack) seen_b_ack++;
            end
            check("ar_row4_rel", 16'(mem[4]), 16'h00);
            check("ar_no_ack", 16'(seen_b_ack), 16'd0);
        end
`endif

        // Reset during an RMW aborts it without an ack and restarts the clear.
        drive_a(1'b1, 4'd9, 3'd1, 1'b1);
        ticks(2);
        reset = 1'b1;
        tick();
        a_req = 1'b0;
        check("rr_ack", 16'(a_ack), 16'd0);
        check("rr_state", 16'(state_dbg), 16'(ST_CLR));
        check("rr_busy", 16'(busy), 16'd1);
        reset = 1'b0;
        ticks(16);
        check("rr_busy_done", 16'(busy), 16'd0);
        check("rr_row9", 16'(mem[9]), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
